// File: rtl/music_note_sequencer_if.sv
// Control/ROM bundle for music_note_sequencer: the sequencer sits on the slave
// modport, the player/ROM environment on the master modport.
interface music_note_sequencer_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_q;
    logic              note_valid;
    logic [ADDR_W-1:0] note_index;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, rom_q,
        input  rom_addr, note_valid, note_index, busy, done
    );

    modport slave (
        input  start, stop, rom_q,
        output rom_addr, note_valid, note_index, busy, done
    );
endinterface

// File: rtl/music_note_sequencer.sv
// Walks a duration ROM and sounds each note for rom_q*TICK_DIV clocks.
// Define MUSIC_SEQ_LOOP_EN to repeat the song from address 0 after each done pulse.
module music_note_sequencer #(
    parameter int unsigned TICK_DIV = 12500000,
    parameter int          ADDR_W   = 9
) (
    input  logic                   clock,
    input  logic                   resetn,
    music_note_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_PLAY,
        S_DONE
    } state_t;

    localparam logic [31:0]       TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       presc_q, presc_d;
    logic [7:0]        dur_q, dur_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            presc_q <= '0;
            dur_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            presc_q <= presc_d;
            dur_q   <= dur_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        presc_d = presc_q;
        dur_d   = dur_q;
        case (state_q)
            S_IDLE: begin
                addr_d  = '0;
                presc_d = '0;
                dur_d   = '0;
                if (bus.start && !bus.stop) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                dur_d   = bus.rom_q;
                presc_d = '0;
                state_d = (bus.rom_q == 8'd0) ? S_DONE : S_PLAY;
            end
            S_PLAY: begin
                if (presc_q == TICK_LAST) begin
                    presc_d = '0;
                    dur_d   = dur_q - 8'd1;
                    // Last unit of this note: leave PLAY on the same edge the count hits 0.
                    if (dur_q == 8'd1) begin
                        if (addr_q == ADDR_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = S_ADDR;
                        end
                    end
                end else begin
                    presc_d = presc_q + 32'd1;
                end
            end
            S_DONE: begin
                addr_d  = '0;
                presc_d = '0;
                dur_d   = '0;
`ifdef MUSIC_SEQ_LOOP_EN
                state_d = S_ADDR;
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every other transition, including a pending start.
        if (bus.stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            addr_d  = '0;
            presc_d = '0;
            dur_d   = '0;
        end
    end

    assign bus.rom_addr   = addr_q;
    assign bus.note_index = addr_q;
    assign bus.note_valid = (state_q == S_PLAY);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
endmodule
